fifo_matrix_sync: RTL and testbench



---
 rtl/fifo_pkg.sv | 23 ++
 rtl/fifo_sdp_ram.sv | 37 +++
 rtl/fifo_matrix_sync.sv | 131 +++++++++++++
 tb/tb_fifo_matrix_sync.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the line-buffer FIFO: sizing helper, read-mode constants, FWFT output-stage states.
package fifo_pkg;

  localparam int unsigned FIFO_STD  = 0;
  localparam int unsigned FIFO_FWFT = 1;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_VALID = 1'b1
  } out_state_e;

  // Ceiling log2, usable in parameter expressions.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result = 0;
    int unsigned v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port. The array itself is never reset.
module fifo_sdp_ram
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W = 11,
  parameter int unsigned DEPTH  = 2048,
  localparam int unsigned AW    = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port; only the output register is reset so the visible data starts at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/fifo_matrix_sync.sv
// Parametrised synchronous line FIFO with optional first-word-fall-through output stage.
module fifo_matrix_sync
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W    = 11,
  parameter int unsigned DEPTH     = 2048,
  parameter int unsigned FWFT      = FIFO_STD,
  parameter int unsigned AFULL_TH  = DEPTH - 128,
  parameter int unsigned AEMPTY_TH = 128,
  localparam int unsigned AW       = clog2(DEPTH),
  localparam int unsigned CW       = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [CW-1:0]     count,
  output logic              wr_err,
  output logic              rd_err
);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  out_state_e    state;
  out_state_e    state_n;
  logic          wr_acc;
  logic          rd_acc;
  logic          ram_re;
  logic [CW-1:0] ram_cnt;
  logic [CW-1:0] count_n;
  logic          empty_n;

  // Output-stage state register (stays OUT_EMPTY in standard mode).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= OUT_EMPTY;
    end else begin
      state <= state_n;
    end
  end

  // Acceptance, RAM read issue, next output state and next count.
  always_comb begin
    state_n = state;
    ram_re  = 1'b0;
    wr_acc  = wr_en && !full;
    rd_acc  = rd_en && !empty;
    // Words still in the RAM; in FWFT mode the word on dout has already left it.
    ram_cnt = count - CW'(state == OUT_VALID);
    if (FWFT == FIFO_FWFT) begin
      case (state)
        OUT_EMPTY: begin
          if (ram_cnt != '0) begin
            ram_re  = 1'b1;
            state_n = OUT_VALID;
          end
        end
        OUT_VALID: begin
          if (rd_acc) begin
            if (ram_cnt != '0) begin
              ram_re = 1'b1;
            end else begin
              state_n = OUT_EMPTY;
            end
          end
        end
        default: state_n = OUT_EMPTY;
      endcase
    end else begin
      ram_re = rd_acc;
    end
    count_n = count;
    if (wr_acc && !rd_acc) begin
      count_n = count + CW'(1);
    end else if (rd_acc && !wr_acc) begin
      count_n = count - CW'(1);
    end
    empty_n = (FWFT == FIFO_FWFT) ? (state_n == OUT_EMPTY) : (count_n == '0);
  end

  // Pointers, count, flags and error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      wr_err       <= 1'b0;
      rd_err       <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (ram_re) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count        <= count_n;
      full         <= (count_n == CW'(DEPTH));
      empty        <= empty_n;
      almost_full  <= (count_n >= CW'(AFULL_TH));
      almost_empty <= (count_n <= CW'(AEMPTY_TH));
      wr_err       <= wr_en && full;
      rd_err       <= rd_en && empty;
    end
  end

  // Storage; its read register is dout in both modes.
  fifo_sdp_ram #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (wr_acc),
    .waddr(wr_ptr),
    .wdata(din),
    .re   (ram_re),
    .raddr(rd_ptr),
    .rdata(dout)
  );

endmodule

// File: tb/tb_fifo_matrix_sync.sv
// Bench for fifo_matrix_sync: one standard and one FWFT instance against a queue-based reference model.
module tb_fifo_matrix_sync;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [10:0] s_din = '0, f_din = '0;
  logic        s_wr = 1'b0, s_rd = 1'b0, f_wr = 1'b0, f_rd = 1'b0;
  logic [10:0] s_dout, f_dout;
  logic        s_full, s_empty, s_afull, s_aempty, s_werr, s_rerr;
  logic        f_full, f_empty, f_afull, f_aempty, f_werr, f_rerr;
  logic [4:0]  s_count, f_count;

  fifo_matrix_sync #(.DATA_W(11), .DEPTH(16), .FWFT(0), .AFULL_TH(14), .AEMPTY_TH(2)) u_std (
    .clk(clk), .rst_n(rst_n), .din(s_din), .wr_en(s_wr), .rd_en(s_rd), .dout(s_dout),
    .full(s_full), .empty(s_empty), .almost_full(s_afull), .almost_empty(s_aempty),
    .count(s_count), .wr_err(s_werr), .rd_err(s_rerr));

  fifo_matrix_sync #(.DATA_W(11), .DEPTH(16), .FWFT(1), .AFULL_TH(14), .AEMPTY_TH(2)) u_fwft (
    .clk(clk), .rst_n(rst_n), .din(f_din), .wr_en(f_wr), .rd_en(f_rd), .dout(f_dout),
    .full(f_full), .empty(f_empty), .almost_full(f_afull), .almost_empty(f_aempty),
    .count(f_count), .wr_err(f_werr), .rd_err(f_rerr));

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: words held, last standard read word, FWFT head visibility, error pulses.
  int qs[$];
  int qf[$];
  int m_sdout = 0;
  bit m_fvis = 0;
  bit m_swerr = 0, m_srerr = 0, m_fwerr = 0, m_frerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    qs.delete(); qf.delete();
    m_sdout = 0; m_fvis = 0;
    m_swerr = 0; m_srerr = 0; m_fwerr = 0; m_frerr = 0;
  endtask

  // One clock edge of the behaviour described for both read modes.
  task automatic model_step(input bit ws, input int ds, input bit rs,
                            input bit wf, input int df, input bit rf);
    int  n;
    bit  isfull, isempty, pop, nv;
    n = qs.size();
    isfull = (n == 16); isempty = (n == 0);
    m_swerr = ws && isfull;
    m_srerr = rs && isempty;
    if (rs && !isempty) m_sdout = qs.pop_front();
    if (ws && !isfull) qs.push_back(ds);
    n = qf.size();
    isfull = (n == 16);
    m_fwerr = wf && isfull;
    m_frerr = rf && !m_fvis;
    pop = rf && m_fvis;
    // Head becomes visible one edge after the RAM holds a word; a pop refills only if one remains.
    if (m_fvis) nv = pop ? (n > 1) : 1'b1;
    else nv = (n > 0);
    if (pop) void'(qf.pop_front());
    if (wf && !isfull) qf.push_back(df);
    m_fvis = nv;
  endtask

  task automatic check_model();
    chk("std_dout", 32'(s_dout), 32'(m_sdout));
    chk("std_count", 32'(s_count), 32'(qs.size()));
    chk("std_full", 32'(s_full), 32'(qs.size() == 16));
    chk("std_empty", 32'(s_empty), 32'(qs.size() == 0));
    chk("std_afull", 32'(s_afull), 32'(qs.size() >= 14));
    chk("std_aempty", 32'(s_aempty), 32'(qs.size() <= 2));
    chk("std_wr_err", 32'(s_werr), 32'(m_swerr));
    chk("std_rd_err", 32'(s_rerr), 32'(m_srerr));
    chk("fwft_count", 32'(f_count), 32'(qf.size()));
    chk("fwft_full", 32'(f_full), 32'(qf.size() == 16));
    chk("fwft_empty", 32'(f_empty), 32'(!m_fvis));
    chk("fwft_afull", 32'(f_afull), 32'(qf.size() >= 14));
    chk("fwft_aempty", 32'(f_aempty), 32'(qf.size() <= 2));
    chk("fwft_wr_err", 32'(f_werr), 32'(m_fwerr));
    chk("fwft_rd_err", 32'(f_rerr), 32'(m_frerr));
    if (m_fvis) chk("fwft_dout", 32'(f_dout), 32'(qf[0]));
  endtask

  task automatic cycle(input bit ws, input int ds, input bit rs,
                       input bit wf, input int df, input bit rf);
    s_wr = ws; s_din = 11'(ds); s_rd = rs;
    f_wr = wf; f_din = 11'(df); f_rd = rf;
    @(posedge clk); #1;
    model_step(ws, ds, rs, wf, df, rf);
    check_model();
  endtask

  task automatic cs(input bit w, input int d, input bit r);
    cycle(w, d, r, 1'b0, 0, 1'b0);
  endtask

  task automatic cf(input bit w, input int d, input bit r);
    cycle(1'b0, 0, 1'b0, w, d, r);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_std_count"}, 32'(s_count), 0);
    chk({tag, "_std_dout"}, 32'(s_dout), 0);
    chk({tag, "_std_flags"}, 32'({s_empty, s_aempty, s_full, s_afull, s_werr, s_rerr}), 32'b110000);
    chk({tag, "_fwft_count"}, 32'(f_count), 0);
    chk({tag, "_fwft_dout"}, 32'(f_dout), 0);
    chk({tag, "_fwft_flags"}, 32'({f_empty, f_aempty, f_full, f_afull, f_werr, f_rerr}), 32'b110000);
  endtask

  typedef struct {
    int wr; int rd; int din;
    int count; int empty; int full; int werr; int rerr; int aempty; int dout;
  } vec_t;
  vec_t tbl[8];

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int got[$];
    int next_w;
    // Underflow, simultaneous access at empty and the almost_empty 2->3 step; starts empty with dout=0x010.
    tbl[0] = '{1, 1, 'h100, 1, 0, 0, 0, 1, 1, 'h010};
    tbl[1] = '{1, 0, 'h101, 2, 0, 0, 0, 0, 1, 'h010};
    tbl[2] = '{1, 0, 'h102, 3, 0, 0, 0, 0, 0, 'h010};
    tbl[3] = '{0, 1, 0,     2, 0, 0, 0, 0, 1, 'h100};
    tbl[4] = '{0, 1, 0,     1, 0, 0, 0, 0, 1, 'h101};
    tbl[5] = '{0, 1, 0,     0, 1, 0, 0, 0, 1, 'h102};
    tbl[6] = '{0, 1, 0,     0, 1, 0, 0, 1, 1, 'h102};
    tbl[7] = '{0, 0, 0,     0, 1, 0, 0, 0, 1, 'h102};

    #1 rst_n = 1'b0;
    #1 check_reset_values("reset");
    model_reset();
    @(negedge clk) rst_n = 1'b1;

    // Standard fill, almost_full 13->14 and full on the 16th write.
    for (int i = 1; i <= 16; i++) begin
      cs(1'b1, i, 1'b0);
      chk("fill_count", 32'(s_count), 32'(i));
      chk("fill_full", 32'(s_full), 32'(i == 16));
      chk("fill_afull", 32'(s_afull), 32'(i >= 14));
    end
    cs(1'b1, 'h7FF, 1'b0);
    chk("ovf_wr_err", 32'(s_werr), 1);
    chk("ovf_count", 32'(s_count), 16);
    cs(1'b0, 0, 1'b0);
    chk("ovf_pulse_end", 32'(s_werr), 0);

    // Drain: data in order, one cycle after each read; almost_full drops at 14->13.
    for (int i = 1; i <= 16; i++) begin
      cs(1'b0, 0, 1'b1);
      chk("drain_dout", 32'(s_dout), 32'(i));
      chk("drain_afull", 32'(s_afull), 32'((16 - i) >= 14));
    end
    chk("drain_empty", 32'(s_empty), 1);

    foreach (tbl[k]) begin
      cs(1'(tbl[k].wr), tbl[k].din, 1'(tbl[k].rd));
      chk("tbl_count", 32'(s_count), 32'(tbl[k].count));
      chk("tbl_empty", 32'(s_empty), 32'(tbl[k].empty));
      chk("tbl_full", 32'(s_full), 32'(tbl[k].full));
      chk("tbl_wr_err", 32'(s_werr), 32'(tbl[k].werr));
      chk("tbl_rd_err", 32'(s_rerr), 32'(tbl[k].rerr));
      chk("tbl_aempty", 32'(s_aempty), 32'(tbl[k].aempty));
      chk("tbl_dout", 32'(s_dout), 32'(tbl[k].dout));
    end

    // Simultaneous read+write at count 5 keeps count and order.
    for (int k = 0; k < 5; k++) cs(1'b1, 'h200 + k, 1'b0);
    for (int k = 0; k < 10; k++) begin
      cs(1'b1, 'h205 + k, 1'b1);
      chk("rw5_count", 32'(s_count), 5);
      chk("rw5_dout", 32'(s_dout), 32'('h200 + k));
    end
    for (int k = 0; k < 11; k++) cs(1'b1, 'h20F + k, 1'b0);
    chk("refill_full", 32'(s_full), 1);
    cs(1'b1, 'h7FE, 1'b1);
    chk("rwfull_wr_err", 32'(s_werr), 1);
    chk("rwfull_count", 32'(s_count), 15);
    chk("rwfull_dout", 32'(s_dout), 'h20A);
    for (int k = 0; k < 15; k++) cs(1'b0, 0, 1'b1);
    chk("rwfull_drained", 32'(s_empty), 1);

    // FWFT: two-cycle write-to-visible latency.
    cf(1'b1, 'h3A5, 1'b0);
    chk("fwft_lat_empty_n", 32'(f_empty), 1);
    chk("fwft_lat_count", 32'(f_count), 1);
    cf(1'b0, 0, 1'b0);
    chk("fwft_lat_empty_n1", 32'(f_empty), 0);
    chk("fwft_lat_dout", 32'(f_dout), 'h3A5);
    cf(1'b0, 0, 1'b1);
    chk("fwft_pop_empty", 32'(f_empty), 1);

    // FWFT stream of 20 words under continuous pop with interleaved writes.
    for (int k = 0; k < 6; k++) cf(1'b1, k, 1'b0);
    next_w = 6;
    for (int c = 0; c < 200 && got.size() < 20; c++) begin
      bit w;
      w = (next_w < 20) && ((c % 4) != 3);
      if (!f_empty) got.push_back(int'(f_dout));
      cf(w, next_w, 1'b1);
      if (w) next_w++;
    end
    chk("stream_len", 32'(got.size()), 20);
    foreach (got[k]) chk("stream_word", 32'(got[k]), 32'(k));
    cf(1'b0, 0, 1'b0);

    // Asynchronous reset with 9 words stored in each instance.
    for (int k = 0; k < 9; k++) cycle(1'b1, 'h50 + k, 1'b0, 1'b1, 'h60 + k, 1'b0);
    chk("pre_rst_count", 32'(s_count), 9);
    #2 rst_n = 1'b0;
    #1 check_reset_values("async_rst");
    model_reset();
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 'h0A1 + k, 1'b0, 1'b1, 'h0A1 + k, 1'b0);
      chk("post_rst_count", 32'(s_count), 32'(k + 1));
    end
    for (int k = 0; k < 3; k++) begin
      chk("post_rst_fwft_dout", 32'(f_dout), 32'('h0A1 + k));
      cycle(1'b0, 0, 1'b1, 1'b0, 0, 1'b1);
      chk("post_rst_std_dout", 32'(s_dout), 32'('h0A1 + k));
    end

    // Push both pointers past DEPTH-1.
    for (int k = 0; k < 14; k++) cycle(1'b1, 'h300 + k, 1'b0, 1'b1, 'h400 + k, 1'b0);
    for (int k = 0; k < 14; k++) cycle(1'b0, 0, 1'b1, 1'b0, 0, 1'b1);
    cycle(1'b1, 'h155, 1'b0, 1'b1, 'h166, 1'b0);
    cycle(1'b0, 0, 1'b1, 1'b0, 0, 1'b0);
    chk("wrap_std_dout", 32'(s_dout), 'h155);
    chk("wrap_fwft_dout", 32'(f_dout), 'h166);
    cycle(1'b0, 0, 1'b0, 1'b0, 0, 1'b1);

    // Random traffic, alternating fill-biased and drain-biased phases.
    for (int seg = 0; seg < 4; seg++) begin
      int pw;
      pw = (seg % 2 == 0) ? 75 : 25;
      for (int c = 0; c < 100; c++) begin
        cycle($urandom_range(99) < pw, int'($urandom_range(2047)), $urandom_range(99) >= pw,
              $urandom_range(99) < pw, int'($urandom_range(2047)), $urandom_range(99) >= pw);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
